// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared FSM encoding and sizing helpers for the sequential magnitude comparator
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk configuration still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one CHUNK-bit slice
module chunk_cmp
   import cmp_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/seq_mag_cmp.sv
// rtl/seq_mag_cmp.sv - multi-cycle magnitude comparator, MSB chunk first, valid/ready result
module seq_mag_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int CHUNK      = DEF_CHUNK,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int                NCHUNK   = nchunk(WIDTH, CHUNK);
   localparam int                IDX_W    = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0]  SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] y_r;
   logic [IDX_W-1:0] idx;
   logic             decided;
   logic             dec_gt;
   logic             eq_r;
   logic             gt_r;
   logic             lt_r;
   logic [CHUNK-1:0] cx;
   logic [CHUNK-1:0] cy;
   logic             c_eq;
   logic             c_gt;
   logic             c_lt;
   logic             accept;
   logic             last_chunk;
   logic             finish;

   assign cx = x_r[idx*CHUNK +: CHUNK];
   assign cy = y_r[idx*CHUNK +: CHUNK];

   chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .a  (cx),
      .b  (cy),
      .eq (c_eq),
      .gt (c_gt),
      .lt (c_lt)
   );

   assign accept     = in_valid & in_ready;
   assign last_chunk = (idx == '0);
   assign finish     = (state == CMP) & (last_chunk | ((EARLY_EXIT != 0) & ~c_eq));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)    state_nx = CMP;
         CMP:     if (finish)    state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = rst_n;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r     <= '0;
         y_r     <= '0;
         idx     <= IDX_TOP;
         decided <= 1'b0;
         dec_gt  <= 1'b0;
         eq_r    <= 1'b0;
         gt_r    <= 1'b0;
         lt_r    <= 1'b0;
      end else if (accept) begin
         x_r     <= signed_mode ? (x ^ SIGN_BIT) : x;
         y_r     <= signed_mode ? (y ^ SIGN_BIT) : y;
         idx     <= IDX_TOP;
         decided <= 1'b0;
         dec_gt  <= 1'b0;
      end else if (state == CMP) begin
         if (!decided && !c_eq) begin
            decided <= 1'b1;
            dec_gt  <= c_gt;
         end
         if (finish) begin
            eq_r <= ~decided & c_eq;
            gt_r <= decided ? dec_gt  : c_gt;
            lt_r <= decided ? ~dec_gt : c_lt;
         end else begin
            idx <= idx - 1'b1;
         end
      end
   end

   assign eq = eq_r;
   assign gt = gt_r;
   assign lt = lt_r;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// tb/tb_seq_mag_cmp.sv - scoreboard bench for seq_mag_cmp against an arithmetic reference
module tb_seq_mag_cmp;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, signed_mode, out_valid, out_ready;
   logic [WIDTH-1:0] x, y;
   logic             eq, gt, lt;

   logic             in_valid0, in_ready0, out_valid0;
   logic [WIDTH-1:0] x0, y0;
   logic             eq0, gt0, lt0;

   always #5 clk = ~clk;

   seq_mag_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .eq(eq), .gt(gt), .lt(lt)
   );

   seq_mag_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .x(x0), .y(y0), .signed_mode(1'b0), .out_valid(out_valid0),
      .out_ready(1'b1), .eq(eq0), .gt(gt0), .lt(lt0)
   );

   typedef struct {
      logic eq;
      logic gt;
      logic lt;
      int   k;
      int   acc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   ready_mode = 1;
   bit   seen = 0;
   int   hs_cyc = 0;
   int   last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: order from plain signed/unsigned arithmetic; chunks examined from
   // the position of the most significant differing bit.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic m, input int acc);
      exp_t e;
      int   d;
      d     = int'(a ^ b);
      e.eq  = (a == b);
      e.gt  = m ? ($signed(a) > $signed(b)) : (a > b);
      e.lt  = m ? ($signed(a) < $signed(b)) : (a < b);
      e.k   = (d == 0) ? NCHUNK : NCHUNK - (($clog2(d + 1) - 1) / CHUNK);
      e.acc = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         seen      = 0;
         out_ready = 1'b0;
      end else begin
         case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               if (!seen) begin
                  chk("latency", cyc - sb[0].acc, sb[0].k);
                  seen = 1;
               end
               chk("onehot", int'(eq) + int'(gt) + int'(lt), 1);
               chk("result", {eq, gt, lt}, {sb[0].eq, sb[0].gt, sb[0].lt});
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen   = 0;
                  hs_cyc = cyc + 1;
               end
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
      int n = 0;
      @(negedge clk);
      x = a; y = b; signed_mode = m; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      last_acc = cyc + 1;
      sb.push_back(model(a, b, m, last_acc));
      @(negedge clk);
      in_valid = 1'b0;
      x = 16'($urandom); y = 16'($urandom); signed_mode = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic send0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] exp_egl);
      int acc0;
      int n = 0;
      @(negedge clk);
      x0 = a; y0 = b; in_valid0 = 1'b1;
      chk("ee0_ready", in_ready0, 1);
      acc0 = cyc + 1;
      @(negedge clk);
      in_valid0 = 1'b0;
      while (!out_valid0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ee0_latency", cyc - acc0, NCHUNK);
      chk("ee0_result", {eq0, gt0, lt0}, exp_egl);
   endtask

   logic [WIDTH-1:0] dx [5] = '{16'h1234, 16'h9000, 16'h9000, 16'h00A5, 16'h8000};
   logic [WIDTH-1:0] dy [5] = '{16'h1234, 16'h1FFF, 16'h1FFF, 16'h00A6, 16'h7FFF};
   logic             dm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [2:0]       de [5] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; signed_mode = 1'b0;
      in_valid0 = 1'b0; x0 = '0; y0 = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_egl", {eq, gt, lt}, 3'b000);
      chk("rst_in_ready0", in_ready0, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 5; i++) begin
         send(dx[i], dy[i], dm[i]);
         drain();
         chk("directed_hold", {eq, gt, lt}, de[i]);
      end

      send0(16'h9000, 16'h1FFF, 3'b010);
      send0(16'h00A5, 16'h00A6, 3'b001);

      @(posedge clk); #1 ready_mode = 2;
      send(16'h00A5, 16'h00A6, 1'b0);
      for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_egl", {eq, gt, lt}, 3'b001);
         if (i == 1) begin
            x = '0; y = '0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1 ready_mode = 1;
      send(16'h1234, 16'hF234, 1'b1);
      chk("b2b_accept_cycle", last_acc, hs_cyc + 1);
      drain();

      send(16'h1234, 16'h1234, 1'b0);
      @(posedge clk); #2 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_egl", {eq, gt, lt}, 3'b000);
      sb.delete();
      @(posedge clk); #2 rst_n = 1'b1;
      send(16'hFFFF, 16'h0000, 1'b0);
      chk("postrst_acc_k", sb.size() > 0 ? sb[0].k : -1, 1);
      drain();
      chk("postrst_gt", {eq, gt, lt}, 3'b010);

      @(posedge clk); #1 ready_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [WIDTH-1:0] a, b;
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ (16'h1 << $urandom_range(0, 15));
            2:       b = 16'($urandom);
            default: b = a ^ 16'($urandom_range(0, 15));
         endcase
         send(a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) @(negedge clk);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
